// File: rtl/bp_pkg.sv
// Shared constants and saturating-counter encoding helpers for the branch predictor table.
package bp_pkg;

    localparam int DEF_NUM_BANKS = 4;
    localparam int DEF_INDEX_W   = 2;
    localparam int DEF_CTR_W     = 2;
    localparam int DEF_HIST_W    = 0;
    localparam int DEF_BYPASS    = 0;

    // Strongly taken: all ones.
    function automatic int ctr_max(input int ctr_w);
        return (1 << ctr_w) - 1;
    endfunction

    // Weakly not taken: the value just below the taken threshold.
    function automatic int ctr_wnt(input int ctr_w);
        return (1 << (ctr_w - 1)) - 1;
    endfunction

    // Counters at or above this value predict taken.
    function automatic int ctr_thresh(input int ctr_w);
        return 1 << (ctr_w - 1);
    endfunction

endpackage

// File: rtl/bp_counter_bank.sv
// One bank of saturating counters: one combinational read port, one saturating update port.
module bp_counter_bank
    import bp_pkg::*;
#(
    parameter int INDEX_W = DEF_INDEX_W,
    parameter int CTR_W   = DEF_CTR_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [INDEX_W-1:0] i_rd_idx,
    output logic [CTR_W-1:0]   o_rd_ctr,
    input  logic               i_wr_en,
    input  logic               i_wr_taken,
    input  logic [INDEX_W-1:0] i_wr_idx,
    output logic [CTR_W-1:0]   o_wr_next
);

    localparam int DEPTH = 1 << INDEX_W;
    localparam logic [CTR_W-1:0] C_MAX = CTR_W'(ctr_max(CTR_W));
    localparam logic [CTR_W-1:0] C_WNT = CTR_W'(ctr_wnt(CTR_W));

    // Held in flops so a same-cycle read always returns the pre-update value.
    logic [CTR_W-1:0] r_ctr [DEPTH];
    logic [CTR_W-1:0] w_wr_cur;

    assign o_rd_ctr = r_ctr[i_rd_idx];
    assign w_wr_cur = r_ctr[i_wr_idx];

    always_comb begin
        o_wr_next = w_wr_cur;
        if (i_wr_taken) begin
            if (w_wr_cur != C_MAX) o_wr_next = w_wr_cur + 1'b1;
        end else begin
            if (w_wr_cur != '0) o_wr_next = w_wr_cur - 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) r_ctr[i] <= C_WNT;
        end else if (i_wr_en) begin
            r_ctr[i_wr_idx] <= o_wr_next;
        end
    end

endmodule

// File: rtl/branch_predictor_table.sv
// Banked bimodal/gshare branch predictor: history register, index hashing, bypass and prediction register.
module branch_predictor_table
    import bp_pkg::*;
#(
    parameter int NUM_BANKS = DEF_NUM_BANKS,
    parameter int INDEX_W   = DEF_INDEX_W,
    parameter int CTR_W     = DEF_CTR_W,
    parameter int HIST_W    = DEF_HIST_W,
    parameter int BYPASS    = DEF_BYPASS,
    localparam int OFF_W    = $clog2(NUM_BANKS),
    localparam int HW       = (HIST_W > 0) ? HIST_W : 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 stall,
    input  logic [INDEX_W-1:0]   inst_addr,
    input  logic                 update,
    input  logic                 branch_result,
    input  logic [INDEX_W-1:0]   buffer_addr,
    input  logic [OFF_W-1:0]     buffer_offset,
    output logic [NUM_BANKS-1:0] prediction,
    output logic [HW-1:0]        history
);

    localparam logic [CTR_W-1:0] C_THR = CTR_W'(ctr_thresh(CTR_W));

    logic [INDEX_W-1:0]   w_hist_ext;
    logic [INDEX_W-1:0]   w_look_idx;
    logic [INDEX_W-1:0]   w_upd_idx;
    logic                 w_same_idx;
    logic [NUM_BANKS-1:0] w_wr_en;
    logic [NUM_BANKS-1:0] w_look_pred;
    logic [CTR_W-1:0]     w_rd_ctr  [NUM_BANKS];
    logic [CTR_W-1:0]     w_wr_next [NUM_BANKS];
    logic [CTR_W-1:0]     w_sel_ctr [NUM_BANKS];
    logic [NUM_BANKS-1:0] r_pred;

    generate
        if (HIST_W == 0) begin : g_bimodal
            assign w_hist_ext = '0;
            assign history    = '0;
        end else begin : g_gshare
            logic [HIST_W-1:0] r_hist;
            always_ff @(posedge clock or posedge reset) begin
                if (reset) r_hist <= '0;
                else if (update) r_hist <= HIST_W'({r_hist, branch_result});
            end
            assign w_hist_ext = INDEX_W'(r_hist);
            assign history    = r_hist;
        end
    endgenerate

    // Both indices hash with the history as it stands before this cycle's shift.
    assign w_look_idx = inst_addr ^ w_hist_ext;
    assign w_upd_idx  = buffer_addr ^ w_hist_ext;
    assign w_same_idx = (w_look_idx == w_upd_idx);

    generate
        for (genvar gb = 0; gb < NUM_BANKS; gb++) begin : g_bank
            assign w_wr_en[gb] = update && (buffer_offset == OFF_W'(gb));

            bp_counter_bank #(
                .INDEX_W (INDEX_W),
                .CTR_W   (CTR_W)
            ) u_bank (
                .clock      (clock),
                .reset      (reset),
                .i_rd_idx   (w_look_idx),
                .o_rd_ctr   (w_rd_ctr[gb]),
                .i_wr_en    (w_wr_en[gb]),
                .i_wr_taken (branch_result),
                .i_wr_idx   (w_upd_idx),
                .o_wr_next  (w_wr_next[gb])
            );

            // Forward only the bank actually written this cycle, and only when enabled.
            assign w_sel_ctr[gb] = ((BYPASS != 0) && w_wr_en[gb] && w_same_idx)
                                   ? w_wr_next[gb] : w_rd_ctr[gb];
            assign w_look_pred[gb] = (w_sel_ctr[gb] >= C_THR);
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_pred <= '0;
        else if (!stall) r_pred <= w_look_pred;
    end

    assign prediction = r_pred;

endmodule

// File: tb/tb_branch_predictor_table.sv
// Bench for branch_predictor_table: three configurations share stimulus and are checked against a table model.
module tb_branch_predictor_table;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       stall = 1'b0;
  logic       update = 1'b0;
  logic       branch_result = 1'b0;
  logic [1:0] inst_addr = 2'd0;
  logic [1:0] buffer_addr = 2'd0;
  logic [1:0] buffer_offset = 2'd0;

  logic [3:0] pred0, pred1, pred2;
  logic       hist0, hist1;
  logic [1:0] hist2;

  int total = 0;
  int bad = 0;

  // model: counter per [instance][line][bank], registered prediction, history value
  int         m_ctr [3][4][4];
  logic [3:0] m_pred [3];
  int         m_hist [3];
  int         p_bypass [3] = '{0, 1, 1};
  int         p_hw [3] = '{0, 0, 2};

  // u0: bimodal, no bypass; u1: bimodal with bypass; u2: gshare HIST_W=2 with bypass
  branch_predictor_table u0 (
    .clock(clock), .reset(reset), .stall(stall), .inst_addr(inst_addr),
    .update(update), .branch_result(branch_result), .buffer_addr(buffer_addr),
    .buffer_offset(buffer_offset), .prediction(pred0), .history(hist0)
  );

  branch_predictor_table #(.BYPASS(1)) u1 (
    .clock(clock), .reset(reset), .stall(stall), .inst_addr(inst_addr),
    .update(update), .branch_result(branch_result), .buffer_addr(buffer_addr),
    .buffer_offset(buffer_offset), .prediction(pred1), .history(hist1)
  );

  branch_predictor_table #(.HIST_W(2), .BYPASS(1)) u2 (
    .clock(clock), .reset(reset), .stall(stall), .inst_addr(inst_addr),
    .update(update), .branch_result(branch_result), .buffer_addr(buffer_addr),
    .buffer_offset(buffer_offset), .prediction(pred2), .history(hist2)
  );

  // clock / reset block
  always #5 clock = ~clock;

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) begin
      for (int l = 0; l < 4; l++)
        for (int b = 0; b < 4; b++) m_ctr[k][l][b] = 1;
      m_pred[k] = 4'b0000;
      m_hist[k] = 0;
    end
  endfunction

  // One clock of behaviour for every configuration, from the current inputs.
  function automatic void model_step();
    for (int k = 0; k < 3; k++) begin
      int h, li, ui, nv;
      h  = m_hist[k];
      li = int'(inst_addr) ^ h;
      ui = int'(buffer_addr) ^ h;
      nv = m_ctr[k][ui][buffer_offset];
      if (branch_result) nv = (nv + 1 > 3) ? 3 : nv + 1;
      else               nv = (nv - 1 < 0) ? 0 : nv - 1;
      if (!stall) begin
        for (int b = 0; b < 4; b++) begin
          int c;
          c = m_ctr[k][li][b];
          if (p_bypass[k] != 0 && update && li == ui && b == int'(buffer_offset)) c = nv;
          m_pred[k][b] = (c >= 2);
        end
      end
      if (update) begin
        m_ctr[k][ui][buffer_offset] = nv;
        if (p_hw[k] > 0) m_hist[k] = ((h << 1) | int'(branch_result)) & ((1 << p_hw[k]) - 1);
      end
    end
  endfunction

  // driver tasks
  task automatic set_in(input logic st, input logic [1:0] ia, input logic up,
                        input logic br, input logic [1:0] ba, input logic [1:0] bo);
    stall = st; inst_addr = ia; update = up; branch_result = br;
    buffer_addr = ba; buffer_offset = bo;
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
  endtask

  // Asserts reset between edges with an update pending, holds it over one edge.
  task automatic apply_reset();
    update = 1'b1; branch_result = 1'b1;
    #2;
    reset = 1'b1;
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
    update = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    @(posedge clock); @(posedge clock); #3;
    total += 4;
    if ({pred0, pred1, pred2} !== 12'h000) begin
      bad++; $display("FAIL reset_pred got=%h/%h/%h want=0/0/0", pred0, pred1, pred2);
    end
    if (hist0 !== 1'b0) begin bad++; $display("FAIL reset_hist0 got=%b want=0", hist0); end
    if (hist1 !== 1'b0) begin bad++; $display("FAIL reset_hist1 got=%b want=0", hist1); end
    if (hist2 !== 2'b00) begin bad++; $display("FAIL reset_hist2 got=%b want=00", hist2); end
    @(posedge clock); #1;
    reset = 1'b0;
    set_in(0, 2'd0, 0, 0, 2'd0, 2'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if ({pred0, pred1, pred2} !== 12'h000) begin
        bad++; $display("FAIL idle_pred cyc=%0d got=%h/%h/%h want=0/0/0", i, pred0, pred1, pred2);
      end
    end
  endtask

  task automatic test_count_up();
    apply_reset();
    set_in(0, 2'd1, 1, 1, 2'd1, 2'd2);
    tick();  // counter 1 -> 2; u0 sees old value, u1 forwards new one
    total += 2;
    if (pred0 !== 4'b0000) begin bad++; $display("FAIL up1_u0 got=%b want=0000", pred0); end
    if (pred1 !== 4'b0100) begin bad++; $display("FAIL up1_u1 got=%b want=0100", pred1); end
    tick();  // 2 -> 3
    total++;
    if (pred0 !== 4'b0100) begin bad++; $display("FAIL up2_u0 got=%b want=0100", pred0); end
    tick();  // 3 -> 3
    tick();  // 3 -> 3 again
    set_in(0, 2'd1, 1, 0, 2'd1, 2'd2);
    tick();  // 3 -> 2, still taken if it saturated
    set_in(0, 2'd1, 0, 0, 2'd0, 2'd0);
    tick();
    total += 3;
    if (pred0 !== 4'b0100) begin bad++; $display("FAIL sat_up_u0 got=%b want=0100", pred0); end
    if (pred1 !== 4'b0100) begin bad++; $display("FAIL sat_up_u1 got=%b want=0100", pred1); end
    if (pred2 !== m_pred[2]) begin bad++; $display("FAIL sat_up_u2 got=%b want=%b", pred2, m_pred[2]); end
  endtask

  task automatic test_count_down();
    apply_reset();
    set_in(0, 2'd0, 1, 0, 2'd0, 2'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (pred0[0] !== 1'b0) begin bad++; $display("FAIL down%0d_u0 got=%b want=0", i, pred0[0]); end
    end
    set_in(0, 2'd0, 1, 1, 2'd0, 2'd0);
    tick();  // 0 -> 1
    set_in(0, 2'd0, 0, 0, 2'd0, 2'd0);
    tick();
    total++;
    if (pred0 !== 4'b0000) begin bad++; $display("FAIL sat_down_u0 got=%b want=0000", pred0); end
    set_in(0, 2'd0, 1, 1, 2'd0, 2'd0);
    tick();  // 1 -> 2
    set_in(0, 2'd0, 0, 0, 2'd0, 2'd0);
    tick();
    total += 2;
    if (pred0 !== 4'b0001) begin bad++; $display("FAIL rise_u0 got=%b want=0001", pred0); end
    if (pred2 !== m_pred[2]) begin bad++; $display("FAIL rise_u2 got=%b want=%b", pred2, m_pred[2]); end
  endtask

  task automatic test_stall();
    apply_reset();
    set_in(0, 2'd0, 0, 0, 2'd0, 2'd0);
    tick();
    set_in(1, 2'd0, 1, 1, 2'd0, 2'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      total += 2;
      if (pred0 !== 4'b0000) begin bad++; $display("FAIL stall%0d_u0 got=%b want=0000", i, pred0); end
      if (pred1 !== 4'b0000) begin bad++; $display("FAIL stall%0d_u1 got=%b want=0000", i, pred1); end
    end
    set_in(0, 2'd0, 0, 0, 2'd0, 2'd0);
    tick();
    total += 3;
    if (pred0 !== 4'b0010) begin bad++; $display("FAIL unstall_u0 got=%b want=0010", pred0); end
    if (pred1 !== 4'b0010) begin bad++; $display("FAIL unstall_u1 got=%b want=0010", pred1); end
    if (pred2 !== m_pred[2]) begin bad++; $display("FAIL unstall_u2 got=%b want=%b", pred2, m_pred[2]); end
  endtask

  task automatic test_bypass();
    apply_reset();
    set_in(0, 2'd2, 1, 1, 2'd2, 2'd3);
    tick();
    total += 3;
    if (pred0 !== 4'b0000) begin bad++; $display("FAIL bypass_u0 got=%b want=0000", pred0); end
    if (pred1 !== 4'b1000) begin bad++; $display("FAIL bypass_u1 got=%b want=1000", pred1); end
    if (pred2 !== 4'b1000) begin bad++; $display("FAIL bypass_u2 got=%b want=1000", pred2); end
  endtask

  task automatic test_gshare();
    logic [1:0] exp_h [3] = '{2'b01, 2'b11, 2'b11};
    logic [1:0] look_a [4] = '{2'd3, 2'd2, 2'd0, 2'd1};
    logic       look_b [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    apply_reset();
    set_in(0, 2'd1, 1, 1, 2'd0, 2'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (hist2 !== exp_h[i]) begin bad++; $display("FAIL ghist%0d got=%b want=%b", i, hist2, exp_h[i]); end
    end
    // history 11: inst 3,2,0,1 map to lines 0,1,3,2
    for (int i = 0; i < 4; i++) begin
      set_in(0, look_a[i], 0, 0, 2'd0, 2'd0);
      tick();
      total++;
      if (pred2[0] !== look_b[i]) begin
        bad++; $display("FAIL glook%0d got=%b want=%b", i, pred2[0], look_b[i]);
      end
    end
    set_in(0, 2'd0, 1, 1, 2'd1, 2'd1);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    total += 2;
    if (hist2 !== 2'b00) begin bad++; $display("FAIL async_hist got=%b want=00", hist2); end
    if (pred2 !== 4'b0000) begin bad++; $display("FAIL async_pred got=%b want=0000", pred2); end
    @(posedge clock); #1;
    reset = 1'b0;
    set_in(0, 2'd0, 1, 1, 2'd0, 2'd0);
    tick();
    total += 3;
    if (pred2 !== 4'b0001) begin bad++; $display("FAIL post_rst_u2 got=%b want=0001", pred2); end
    if (pred0 !== 4'b0000) begin bad++; $display("FAIL post_rst_u0 got=%b want=0000", pred0); end
    if (hist2 !== 2'b01) begin bad++; $display("FAIL post_rst_hist got=%b want=01", hist2); end
  endtask

  task automatic test_random();
    for (int r = 0; r < 600; r++) begin
      if (r % 150 == 75) apply_reset();
      set_in(($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      tick();
      total += 6;
      if (pred0 !== m_pred[0]) begin bad++; $display("FAIL rand_pred0 r=%0d got=%b want=%b", r, pred0, m_pred[0]); end
      if (pred1 !== m_pred[1]) begin bad++; $display("FAIL rand_pred1 r=%0d got=%b want=%b", r, pred1, m_pred[1]); end
      if (pred2 !== m_pred[2]) begin bad++; $display("FAIL rand_pred2 r=%0d got=%b want=%b", r, pred2, m_pred[2]); end
      if (hist0 !== 1'(m_hist[0])) begin bad++; $display("FAIL rand_hist0 r=%0d got=%b want=%0d", r, hist0, m_hist[0]); end
      if (hist1 !== 1'(m_hist[1])) begin bad++; $display("FAIL rand_hist1 r=%0d got=%b want=%0d", r, hist1, m_hist[1]); end
      if (hist2 !== 2'(m_hist[2])) begin bad++; $display("FAIL rand_hist2 r=%0d got=%b want=%0d", r, hist2, m_hist[2]); end
    end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_count_down();
    test_stall();
    test_bypass();
    test_gshare();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_predictor_table.md
BRANCH_PREDICTOR_TABLE -- requirements
Module: branch_predictor_table

Interface
REQ-001 The block SHALL have parameter NUM_BANKS, default 4: predictions per fetch line, power of two, 2..8.
REQ-002 The block SHALL have parameter INDEX_W, default 2: line-index width, table depth 2**INDEX_W, 1..7.
REQ-003 The block SHALL have parameter CTR_W, default 2: saturating-counter width, 2..4.
REQ-004 The block SHALL have parameter HIST_W, default 0: global-history length; 0 = bimodal, 1..INDEX_W = gshare.
REQ-005 The block SHALL have parameter BYPASS, default 0: 1 forwards same-cycle update to lookup.
REQ-006 The block SHALL have port clock  input  1  sole clock; all state changes on posedge.
REQ-007 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-008 The block SHALL have port stall  input  1  holds prediction output.
REQ-009 The block SHALL have port inst_addr  input  INDEX_W  lookup line index.
REQ-010 The block SHALL have port update  input  1  update request, one entry per cycle.
REQ-011 The block SHALL have port branch_result  input  1  1 = taken, 0 = not taken.
REQ-012 The block SHALL have port buffer_addr  input  INDEX_W  update line index.
REQ-013 The block SHALL have port buffer_offset  input  log2(NUM_BANKS)  update bank select.
REQ-014 The block SHALL have port prediction  output  NUM_BANKS  bit b = taken prediction for bank b.
REQ-015 The block SHALL have port history  output  max(HIST_W,1)  current global history; 0 when HIST_W=0.

Function
REQ-016 Counter encoding SHALL be: 0 = strong not taken; 2**CTR_W-1 = strong taken; WNT = 2**(CTR_W-1)-1.
REQ-017 Bit b SHALL predict taken iff counter >= 2**(CTR_W-1).
REQ-018 Lookup index SHALL be inst_addr XOR zero-extended history; it SHALL be inst_addr when HIST_W=0.
REQ-019 Update index SHALL be buffer_addr XOR history, using the history value before this cycle's shift.
REQ-020 With stall=0, prediction SHALL register the lookup result at posedge: 1-cycle latency.
REQ-021 With stall=1, prediction SHALL hold its previous value.
REQ-022 Table update and history shift SHALL proceed regardless of stall.
REQ-023 With update=1 and branch_result=1, the counter at [update index][buffer_offset] SHALL increment, saturating at max.
REQ-024 With update=1 and branch_result=0, that counter SHALL decrement, saturating at 0.
REQ-025 All other counters SHALL be unchanged; with update=0, no counter SHALL change.
REQ-026 With update=1 and HIST_W>0, history SHALL become {history[HIST_W-2:0], branch_result}; otherwise it SHALL hold.
REQ-027 When lookup and update target the same entry in one cycle: BYPASS=0 SHALL use the pre-update counter; BYPASS=1 SHALL use the post-update counter for that bank only.
REQ-028 With BYPASS=1 and HIST_W>0, the lookup index SHALL still use pre-shift history.
REQ-029 Arithmetic SHALL be done in CTR_W bits; no wrap from max to 0 or from 0 to max.

Reset
REQ-030 While reset=1, all counters SHALL be WNT, history SHALL be 0 and prediction SHALL be 0, independent of clock.
REQ-031 Reset asserted mid-operation SHALL discard any in-flight update in that cycle.
REQ-032 The first update SHALL be accepted at the first posedge after reset deasserts.

Structure
REQ-033 Package bp_pkg SHALL hold the counter-encoding helpers (WNT, taken threshold, max) as functions of CTR_W and the default parameter constants.
REQ-034 One sub-module bp_counter_bank SHALL hold one bank of 2**INDEX_W counters with one read port and one saturating update port; it SHALL be instantiated NUM_BANKS times.
REQ-035 History register, index XOR, bypass mux and prediction register SHALL live in the top module.
REQ-036 The table SHALL be flops, not inferred RAM, so that the REQ-027 read-old semantics hold.

Verification
REQ-037 Reset, then stall=0, inst_addr=0: prediction SHALL be 4'b0000 at every cycle.
REQ-038 Defaults, 3 updates taken to buffer_addr=1, buffer_offset=2, then lookup inst_addr=1: counter SHALL be 1->2->3->3, and prediction SHALL be 4'b0100 one cycle after lookup.
REQ-039 Counter at 0, 2 not-taken updates: counter SHALL stay 0 and prediction bit SHALL stay 0.
REQ-040 stall=1 held 5 cycles while taken updates reach predicted line 0: prediction SHALL be unchanged; after stall drops it SHALL reflect new counters next cycle.
REQ-041 BYPASS=0 vs 1, counter 1, same-cycle taken update and lookup of that entry: prediction bit SHALL be 0 vs 1 respectively.
REQ-042 HIST_W=2, INDEX_W=2, taken updates to buffer_addr=0 with history 00, 01, 11: updates SHALL land at indices 0, 1, 3, and history SHALL read 2'b11; async reset mid-sequence SHALL restore all counters to 1 and history to 0.
